// File: rtl/snn_buf_pkg.sv
// Shared types and defaults for the layer-to-layer ping-pong activation buffer.
package snn_buf_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DEPTH  = 16384;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/bram_1rw.sv
// Single-port RAM with registered read; out-of-range writes are dropped.
module bram_1rw
  import snn_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Rounded up to a power of two so every index value is a legal read.
  logic [DATA_W-1:0] mem [2**IDX_W];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx;
  logic              in_rng;

  assign idx    = addr[IDX_W-1:0];
  assign in_rng = addr_ok(32'(addr), 32'(DEPTH));
  assign rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (we && in_rng) mem[idx] <= wdata;
    rdata_q <= mem[idx];
  end
endmodule

// File: rtl/snn_pingpong_buffer.sv
// Two-bank activation buffer between a producer and a consumer layer engine;
// owns the start/done handshake so fill of frame N+1 overlaps drain of frame N.
module snn_pingpong_buffer
  import snn_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_req,
  output logic              prod_start,
  input  logic              prod_done,
  input  logic [ADDR_W-1:0] prod_address,
  input  logic [DATA_W-1:0] prod_writedata,
  input  logic              prod_write_en,
  output logic [DATA_W-1:0] prod_readdata,
  output logic              cons_start,
  input  logic              cons_done,
  input  logic [ADDR_W-1:0] cons_address,
  input  logic [DATA_W-1:0] cons_writedata,
  input  logic              cons_write_en,
  output logic [DATA_W-1:0] cons_readdata,
  output logic [1:0]        bank_full,
  output logic              overflow
);
  bank_state_t bank_q [2], bank_d [2];
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic prod_busy_q, prod_busy_d, cons_busy_q, cons_busy_d;
  logic pending_q, pending_d, overflow_q, overflow_d;
  logic prod_start_q, prod_start_d, cons_start_q, cons_start_d;
  logic prod_done_prev_q, cons_done_prev_q;
  logic prod_rise, cons_rise;

  assign prod_rise  = prod_done & ~prod_done_prev_q & prod_busy_q;
  assign cons_rise  = cons_done & ~cons_done_prev_q & cons_busy_q;
  assign prod_start = prod_start_q;
  assign cons_start = cons_start_q;
  assign overflow   = overflow_q;

  // Start decisions look only at registered bank state, so a bank freed this
  // cycle becomes startable on the next one.
  always_comb begin
    bank_d       = bank_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    prod_busy_d  = prod_busy_q;
    cons_busy_d  = cons_busy_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    prod_start_d = 1'b0;
    cons_start_d = 1'b0;

    if (prod_rise) begin
      bank_d[wr_bank_q] = FULL;
      wr_bank_d         = ~wr_bank_q;
      prod_busy_d       = 1'b0;
    end
    if ((pending_q || frame_req) && !prod_busy_q && bank_q[wr_bank_q] == EMPTY) begin
      bank_d[wr_bank_q] = FILLING;
      prod_busy_d       = 1'b1;
      prod_start_d      = 1'b1;
      pending_d         = pending_q & frame_req;
    end else if (frame_req) begin
      if (pending_q) overflow_d = 1'b1;
      else           pending_d  = 1'b1;
    end

    if (cons_rise) begin
      bank_d[rd_bank_q] = EMPTY;
      rd_bank_d         = ~rd_bank_q;
      cons_busy_d       = 1'b0;
    end
    if (!cons_busy_q && bank_q[rd_bank_q] == FULL) begin
      bank_d[rd_bank_q] = DRAINING;
      cons_busy_d       = 1'b1;
      cons_start_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]        <= EMPTY;
      bank_q[1]        <= EMPTY;
      wr_bank_q        <= 1'b0;
      rd_bank_q        <= 1'b0;
      prod_busy_q      <= 1'b0;
      cons_busy_q      <= 1'b0;
      pending_q        <= 1'b0;
      overflow_q       <= 1'b0;
      prod_start_q     <= 1'b0;
      cons_start_q     <= 1'b0;
      prod_done_prev_q <= 1'b0;
      cons_done_prev_q <= 1'b0;
    end else begin
      bank_q           <= bank_d;
      wr_bank_q        <= wr_bank_d;
      rd_bank_q        <= rd_bank_d;
      prod_busy_q      <= prod_busy_d;
      cons_busy_q      <= cons_busy_d;
      pending_q        <= pending_d;
      overflow_q       <= overflow_d;
      prod_start_q     <= prod_start_d;
      cons_start_q     <= cons_start_d;
      prod_done_prev_q <= prod_done;
      cons_done_prev_q <= cons_done;
    end
  end

  logic [1:0]        prod_own, cons_own, ram_we;
  logic [ADDR_W-1:0] ram_addr  [2];
  logic [DATA_W-1:0] ram_wdata [2];
  logic [DATA_W-1:0] ram_rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign prod_own[b]  = (bank_q[b] == FILLING);
    assign cons_own[b]  = (bank_q[b] == DRAINING);
    assign bank_full[b] = (bank_q[b] == FULL) || (bank_q[b] == DRAINING);
    assign ram_addr[b]  = cons_own[b] ? cons_address   : prod_address;
    assign ram_wdata[b] = cons_own[b] ? cons_writedata : prod_writedata;
    assign ram_we[b]    = (prod_own[b] & prod_write_en) | (cons_own[b] & cons_write_en);

    bram_1rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
      .clk  (clk),
      .we   (ram_we[b]),
      .addr (ram_addr[b]),
      .wdata(ram_wdata[b]),
      .rdata(ram_rdata[b])
    );
  end

  // Read-side select travels with the address so data lines up with its bank.
  logic prod_rvld_q, prod_rvld_d, prod_rsel_q, prod_rsel_d;
  logic cons_rvld_q, cons_rvld_d, cons_rsel_q, cons_rsel_d;

  always_comb begin
    prod_rvld_d = (|prod_own) && addr_ok(32'(prod_address), 32'(DEPTH));
    prod_rsel_d = prod_own[1];
    cons_rvld_d = (|cons_own) && addr_ok(32'(cons_address), 32'(DEPTH));
    cons_rsel_d = cons_own[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_rvld_q <= 1'b0;
      cons_rvld_q <= 1'b0;
      prod_rsel_q <= 1'b0;
      cons_rsel_q <= 1'b0;
    end else begin
      prod_rvld_q <= prod_rvld_d;
      cons_rvld_q <= cons_rvld_d;
      prod_rsel_q <= prod_rsel_d;
      cons_rsel_q <= cons_rsel_d;
    end
  end

  assign prod_readdata = prod_rvld_q ? ram_rdata[prod_rsel_q] : '0;
  assign cons_readdata = cons_rvld_q ? ram_rdata[cons_rsel_q] : '0;
endmodule

// File: doc/snn_pingpong_buffer.md
Name: snn_pingpong_buffer

Overview:
Double-banked (ping-pong) activation buffer that sits between two layer engines, e.g. conv->LIF or LIF->maxpool. It acts as the memory responder for the producer's dest port (address/writedata/readdata/write_en) and the consumer's src port. It owns the start/done sequencing between the two layers, so the producer can fill frame N+1 while the consumer drains frame N.

Parameters:
DATA_W, 16, word width
ADDR_W, 14, per-bank address width
DEPTH, 16384, words per bank (must be <= 2**ADDR_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
frame_req  in  1  one-cycle pulse: upstream requests one new producer frame
prod_start  out  1  one-cycle start pulse to producer engine
prod_done  in  1  producer done level; rising edge ends the frame
prod_address  in  ADDR_W  producer word address
prod_writedata  in  DATA_W  producer write data
prod_write_en  in  1  producer write strobe
prod_readdata  out  DATA_W  producer read data
cons_start  out  1  one-cycle start pulse to consumer engine
cons_done  in  1  consumer done level; rising edge releases the bank
cons_address  in  ADDR_W  consumer word address
cons_writedata  in  DATA_W  consumer write data (in-place update)
cons_write_en  in  1  consumer write strobe
cons_readdata  out  DATA_W  consumer read data
bank_full  out  2  per-bank FULL/DRAINING flag
overflow  out  1  sticky: frame_req dropped

Behaviour:
- Reset, synchronous, active-high, clk: both banks EMPTY; wr_bank=0; rd_bank=0; prod_busy=0; cons_busy=0; pending=0.
- Reset outputs: prod_start=0, cons_start=0, overflow=0, bank_full=2'b00.
- Reset values of prod_readdata and cons_readdata are don't-care. RAM contents are not cleared.
- Reset mid-operation aborts everything. Any done edge still asserted after reset is ignored: done_prev regs reset to 0, so a level still high produces one edge that is ignored while the side is not busy.
- Bank states (package enum): EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Edge detect: prod_done_rise = prod_done & ~prod_done_prev; same for cons. Edges are ignored when the matching side is not busy.
- Producer FSM:
  - If pending or frame_req, and !prod_busy, and bank[wr_bank]==EMPTY: bank[wr_bank]<=FILLING, prod_busy<=1, prod_start=1 next cycle (registered, exactly 1 cycle), pending cleared.
  - If the start cannot issue, frame_req sets pending.
  - frame_req while pending already set: overflow<=1, request dropped.
- On prod_done_rise: bank[wr_bank]<=FULL, wr_bank<=~wr_bank, prod_busy<=0.
- Consumer FSM:
  - If !cons_busy and bank[rd_bank]==FULL: bank[rd_bank]<=DRAINING, cons_busy<=1, cons_start=1 next cycle.
  - On cons_done_rise: bank[rd_bank]<=EMPTY, rd_bank<=~rd_bank, cons_busy<=0.
- Frames are consumed strictly in production order (rd_bank alternates).
- Latency: prod_done first sampled high at edge k -> bank FULL after edge k -> cons_start high in cycle after edge k+1, provided the consumer is idle.
- Latency: frame_req at edge k with a free bank -> prod_start high in cycle after edge k.
- Simultaneous events: prod_done_rise, cons_done_rise and frame_req in the same cycle are all applied. An EMPTY produced by cons_done_rise is visible to the start logic on the following cycle, not the same cycle.
- Memory:
  - Two single-port sync RAMs, 1-cycle read latency.
  - Bank b is routed to the producer port when in FILLING, to the consumer port when in DRAINING, and is otherwise idle (we forced 0).
  - Writes commit at the clock edge; readdata is valid the cycle after the address is presented.
  - Read mux select is registered with the address.
- Accesses from a side that owns no bank: writes dropped, readdata=0 the next cycle.
- Addresses >= DEPTH: writes dropped, readdata=0.
- bank_full[b]=1 when bank b is FULL or DRAINING.

Decomposition:
- Package snn_buf_pkg: bank_state_t enum (EMPTY, FILLING, FULL, DRAINING); default DATA_W/ADDR_W localparams.
- Sub-module bram_1rw: single-port sync-read RAM (DATA_W, ADDR_W, DEPTH), instantiated twice.
- The ownership FSM and port muxes stay in this block.

Test Plan:
- Basic frame:
  - Stimulus: after reset, frame_req; producer writes addr 0..899 with data=addr+1, then raises prod_done.
  - Response: prod_start one cycle after frame_req; cons_start 2 cycles after prod_done; consumer read of addr 5 returns 6 one cycle later; bank_full=01.
- Overlap:
  - Stimulus: second frame_req during consumer drain; producer writes 0xAAAA to addr 5 in bank 1.
  - Response: prod_start issues immediately; consumer still reads 6 at addr 5 from bank 0.
- Back-pressure:
  - Stimulus: both banks FULL/DRAINING, then frame_req, then another frame_req.
  - Response: first is held pending and prod_start fires 2 cycles after cons_done rises; second sets overflow=1 (sticky).
- Simultaneous events:
  - Stimulus: prod_done_rise and cons_done_rise in the same cycle.
  - Response: wr_bank and rd_bank both flip; the next cons_start targets the just-filled bank; no frame is lost or duplicated over 6 frames (checked by data tag).
- Reset mid-operation:
  - Stimulus: reset during producer fill, with prod_done held high across reset.
  - Response: all outputs at reset values; no cons_start after reset; next frame_req yields prod_start on bank 0.
- Out-of-range access:
  - Stimulus: write to addr DEPTH, and a consumer read while the consumer owns no bank.
  - Response: no RAM change; readdata=0.
